// File: rtl/if_stage_pkg.sv
// if_stage_pkg: next-PC select codes, exception codes and shared helpers for the fetch stage.
package if_stage_pkg;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    function automatic logic [31:0] br_off(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: hazard/redirect inputs, instruction-memory port and IF/ID outputs of the fetch stage.
interface if_stage_if;
    logic        stall;
    logic        clr_D;
    logic [1:0]  npc_sel;
    logic        br_take;
    logic [15:0] imm16_D;
    logic [25:0] imm26_D;
    logic [31:0] jr_addr_D;
    logic [31:0] inst_F;
    logic [31:0] im_addr;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic [4:0]  exc_D;

    modport master (
        output stall, clr_D, npc_sel, br_take, imm16_D, imm26_D, jr_addr_D, inst_F,
        input  im_addr, instr_D, pc_D, pc8_D, exc_D
    );

    modport slave (
        input  stall, clr_D, npc_sel, br_take, imm16_D, imm26_D, jr_addr_D, inst_F,
        output im_addr, instr_D, pc_D, pc8_D, exc_D
    );
endinterface

// File: rtl/if_stage_npc.sv
// if_stage_npc: combinational next-PC calculator for sequential fetch, branch, j/jal and jr/jalr.
module if_stage_npc
    import if_stage_pkg::*;
(
    input  logic [1:0]  npc_sel_i,
    input  logic        br_take_i,
    input  logic [31:0] pc_f_i,
    input  logic [31:0] pc_d_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] npc_o
);
    npc_sel_e sel;
    assign sel = npc_sel_e'(npc_sel_i);

    // Branch and jump targets are relative to the instruction in D, not the delay slot in F.
    always_comb
        npc_o = sel == NPC_JR ? jr_addr_i :
                sel == NPC_J ? {pc_d_i[31:28], imm26_i, 2'b00} :
                sel == NPC_BR && br_take_i ? pc_d_i + 32'd4 + br_off(imm16_i) :
                pc_f_i + 32'd4;
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage holding PC_F and the IF/ID register.
// Defining IF_ADDR_EXC_EN enables AdEL detection on misaligned or out-of-range fetch addresses.
module if_stage
    import if_stage_pkg::*;
#(
`ifdef IF_ADDR_EXC_EN
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096,
`endif
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic      clk,
    input logic      reset,
    if_stage_if.slave bus
);
    logic [31:0] pcf_q, pcf_d, npc;
    logic [31:0] instr_q, instr_d, pcd_q, pcd_d, pc8_q, pc8_d;
    logic [4:0]  exc_q, exc_d;
    logic        adel;

    if_stage_npc u_npc (
        .npc_sel_i (bus.npc_sel),
        .br_take_i (bus.br_take),
        .pc_f_i    (pcf_q),
        .pc_d_i    (pcd_q),
        .imm16_i   (bus.imm16_D),
        .imm26_i   (bus.imm26_D),
        .jr_addr_i (bus.jr_addr_D),
        .npc_o     (npc)
    );

`ifdef IF_ADDR_EXC_EN
    localparam logic [31:0] IM_SPAN = 32'(4 * IM_WORDS);
    logic [31:0] im_off;
    // Addresses below IM_BASE wrap to a huge offset, so one compare covers both bounds.
    assign im_off = pcf_q - IM_BASE;
    assign adel = |pcf_q[1:0] || im_off >= IM_SPAN;
`else
    assign adel = 1'b0;
`endif

    always_comb begin
        pcf_d   = bus.stall ? pcf_q : npc;
        instr_d = bus.stall ? instr_q : bus.clr_D || adel ? '0 : bus.inst_F;
        pcd_d   = bus.stall ? pcd_q : bus.clr_D ? '0 : pcf_q;
        pc8_d   = bus.stall ? pc8_q : bus.clr_D ? '0 : pcf_q + 32'd8;
        exc_d   = bus.stall ? exc_q : bus.clr_D ? EXC_NONE : adel ? EXC_ADEL : EXC_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q   <= RESET_PC;
            instr_q <= '0;
            pcd_q   <= '0;
            pc8_q   <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            pcf_q   <= pcf_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc8_q   <= pc8_d;
            exc_q   <= exc_d;
        end
    end

    assign bus.im_addr = pcf_q;
    assign bus.instr_D = instr_q;
    assign bus.pc_D    = pcd_q;
    assign bus.pc8_D   = pc8_q;
    assign bus.exc_D   = exc_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a cycle-level behavioural model.
module tb_if_stage;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    if_stage_if bus ();
    if_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    assign bus.inst_F = imem(bus.im_addr);

    function automatic bit fault(input logic [31:0] a);
`ifdef IF_ADDR_EXC_EN
        return a[1:0] != 2'b00 || a < 32'h3000 || a >= 32'h7000;
`else
        return 1'b0;
`endif
    endfunction

    logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
    logic [4:0]  m_exc;

    function automatic logic [132:0] dut_vec();
        return {bus.im_addr, bus.instr_D, bus.pc_D, bus.pc8_D, bus.exc_D};
    endfunction

    function automatic logic [132:0] mdl_vec();
        return {m_pc, m_instr, m_pcd, m_pc8, m_exc};
    endfunction

    function automatic logic [132:0] ld_vec(input logic [31:0] pcf, input logic [31:0] pcd);
        return fault(pcd) ? {pcf, 32'h0, pcd, pcd + 32'd8, 5'd4}
                          : {pcf, imem(pcd), pcd, pcd + 32'd8, 5'd0};
    endfunction

    task automatic model_step();
        logic [31:0] nxt;
        if (reset) begin
            m_pc = 32'h3000; m_instr = 0; m_pcd = 0; m_pc8 = 0; m_exc = 0;
        end else begin
            case (bus.npc_sel)
                2'd1: nxt = bus.br_take ? m_pcd + 32'd4 + 32'(int'($signed(bus.imm16_D)) * 4) : m_pc + 32'd4;
                2'd2: nxt = (m_pcd & 32'hF000_0000) + {4'h0, bus.imm26_D, 2'b00};
                2'd3: nxt = bus.jr_addr_D;
                default: nxt = m_pc + 32'd4;
            endcase
            if (!bus.stall) begin
                if (bus.clr_D) begin
                    m_instr = 0; m_pcd = 0; m_pc8 = 0; m_exc = 0;
                end else begin
                    m_pcd = m_pc; m_pc8 = m_pc + 32'd8;
                    m_instr = fault(m_pc) ? 32'h0 : imem(m_pc);
                    m_exc = fault(m_pc) ? 5'd4 : 5'd0;
                end
                m_pc = nxt;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; bus.stall = 0; bus.clr_D = 0; bus.npc_sel = 0; bus.br_take = 0;
        bus.imm16_D = 0; bus.imm26_D = 0; bus.jr_addr_D = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dut_vec() !== {32'h3000, 101'h0}) begin
                errors++; $display("FAIL reset[%0d] got %h want %h", i, dut_vec(), {32'h3000, 101'h0});
            end
        end
    endtask

    task automatic test_sequential();
        reset = 0;
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3004, 32'h3000)) begin
            errors++; $display("FAIL seq0 got %h want %h", dut_vec(), ld_vec(32'h3004, 32'h3000));
        end
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3008, 32'h3004)) begin
            errors++; $display("FAIL seq1 got %h want %h", dut_vec(), ld_vec(32'h3008, 32'h3004));
        end
    endtask

    task automatic test_branch();
        bus.npc_sel = 1; bus.br_take = 1; bus.imm16_D = 16'hFFFE;
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3000, 32'h3008)) begin
            errors++; $display("FAIL br_taken got %h want %h", dut_vec(), ld_vec(32'h3000, 32'h3008));
        end
        bus.br_take = 0;
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3004, 32'h3000)) begin
            errors++; $display("FAIL br_not_taken got %h want %h", dut_vec(), ld_vec(32'h3004, 32'h3000));
        end
    endtask

    task automatic test_jump();
        bus.npc_sel = 2; bus.imm26_D = 26'h0000C10;
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3040, 32'h3004)) begin
            errors++; $display("FAIL j got %h want %h", dut_vec(), ld_vec(32'h3040, 32'h3004));
        end
        bus.npc_sel = 3; bus.jr_addr_D = 32'h3100;
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3100, 32'h3040)) begin
            errors++; $display("FAIL jr got %h want %h", dut_vec(), ld_vec(32'h3100, 32'h3040));
        end
        bus.npc_sel = 0;
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3104, 32'h3100)) begin
            errors++; $display("FAIL jr_target got %h want %h", dut_vec(), ld_vec(32'h3104, 32'h3100));
        end
    endtask

    task automatic test_stall();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.clr_D = (i == 1);
            bus.npc_sel = (i == 2) ? 2'd3 : 2'd0;
            tick();
            checks++;
            if (dut_vec() !== ld_vec(32'h3104, 32'h3100)) begin
                errors++; $display("FAIL stall[%0d] got %h want %h", i, dut_vec(), ld_vec(32'h3104, 32'h3100));
            end
        end
        bus.stall = 0; bus.clr_D = 0; bus.npc_sel = 0;
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3108, 32'h3104)) begin
            errors++; $display("FAIL stall_release got %h want %h", dut_vec(), ld_vec(32'h3108, 32'h3104));
        end
    endtask

    task automatic test_clear();
        bus.clr_D = 1;
        tick();
        checks++;
        if (dut_vec() !== {32'h310C, 101'h0}) begin
            errors++; $display("FAIL clr got %h want %h", dut_vec(), {32'h310C, 101'h0});
        end
        bus.clr_D = 0; bus.stall = 1; bus.npc_sel = 3; reset = 1;
        tick();
        checks++;
        if (dut_vec() !== {32'h3000, 101'h0}) begin
            errors++; $display("FAIL reset_in_stall got %h want %h", dut_vec(), {32'h3000, 101'h0});
        end
        reset = 0; bus.stall = 0; bus.npc_sel = 0;
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3004, 32'h3000)) begin
            errors++; $display("FAIL post_reset got %h want %h", dut_vec(), ld_vec(32'h3004, 32'h3000));
        end
    endtask

    task automatic test_adel();
        logic [132:0] exp;
        bus.npc_sel = 3; bus.jr_addr_D = 32'h3002;
        tick();
        checks++;
        if (dut_vec() !== ld_vec(32'h3002, 32'h3004)) begin
            errors++; $display("FAIL jr_misaligned got %h want %h", dut_vec(), ld_vec(32'h3002, 32'h3004));
        end
        bus.npc_sel = 0;
        tick();
`ifdef IF_ADDR_EXC_EN
        exp = {32'h3006, 32'h0, 32'h3002, 32'h300A, 5'd4};
`else
        exp = {32'h3006, imem(32'h3002), 32'h3002, 32'h300A, 5'd0};
`endif
        checks++;
        if (dut_vec() !== exp) begin
            errors++; $display("FAIL adel_misaligned got %h want %h", dut_vec(), exp);
        end
        bus.npc_sel = 3; bus.jr_addr_D = 32'h7000;
        tick();
        bus.npc_sel = 0;
        tick();
`ifdef IF_ADDR_EXC_EN
        exp = {32'h7004, 32'h0, 32'h7000, 32'h7008, 5'd4};
`else
        exp = {32'h7004, imem(32'h7000), 32'h7000, 32'h7008, 5'd0};
`endif
        checks++;
        if (dut_vec() !== exp) begin
            errors++; $display("FAIL adel_range got %h want %h", dut_vec(), exp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.clr_D = ($urandom_range(0, 6) == 0);
            bus.npc_sel = 2'($urandom_range(0, 3));
            bus.br_take = 1'($urandom);
            bus.imm16_D = 16'($urandom);
            bus.imm26_D = ($urandom_range(0, 1) == 0) ? 26'(32'h0C00 + $urandom_range(0, 16'hFFF)) : 26'($urandom);
            bus.jr_addr_D = ($urandom_range(0, 4) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL random[%0d] got %h want %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_clear();
        test_adel();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the PC (PC_F) and drives the instruction-memory address.
- Computes the next PC from D-stage redirect requests (branch, j/jal, jr/jalr).
- Registers the fetched word plus its PC into the IF/ID pipeline register for the decode stage.
- Branches and jumps resolve in D with one delay slot: the instruction already in F is always kept.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest valid instruction address.
- IM_WORDS, 4096, instruction-memory depth in words. Valid range is IM_BASE .. IM_BASE+4*IM_WORDS-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC_F and IF/ID.
- clr_D  in  1  load a bubble into IF/ID.
- npc_sel  in  2  next-PC select: 0=PC4, 1=BR, 2=J, 3=JR.
- br_take  in  1  branch condition true (meaningful only when npc_sel=BR).
- imm16_D  in  16  branch offset from the D-stage instruction.
- imm26_D  in  26  jump index from the D-stage instruction.
- jr_addr_D  in  32  forwarded rs value.
- inst_F  in  32  instruction-memory read data (combinational on im_addr).
- im_addr  out  32  equals PC_F.
- instr_D  out  32  IF/ID instruction.
- pc_D  out  32  IF/ID PC.
- pc8_D  out  32  IF/ID PC+8 (link address).
- exc_D  out  5  IF/ID exception code; 0 = none.

Behaviour:
- Reset, synchronous, highest priority: PC_F=RESET_PC; instr_D=0, pc_D=0, pc8_D=0, exc_D=0.
- Next-PC selection:
  - PC4: PC_F+4.
  - BR: if br_take, pc_D+4+(sext(imm16_D)<<2); else PC_F+4.
  - J: {pc_D[31:28], imm26_D, 2'b00}.
  - JR: jr_addr_D.
- All additions are 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is silent.
- PC update: if !stall, PC_F <= NPC; if stall, PC_F holds.
- IF/ID update, priority reset > stall > clr_D > load:
  - stall: hold all fields.
  - clr_D (and !stall): instr_D=0, pc_D=0, pc8_D=0, exc_D=0.
  - load: instr_D=inst_F, pc_D=PC_F, pc8_D=PC_F+8.
- Simultaneous stall and clr_D: stall wins. clr_D is ignored that cycle.
- Latency:
  - im_addr follows PC_F with zero delay.
  - The fetched word appears on instr_D one cycle after PC_F is presented.
  - A redirect issued in D while the branch is in D takes effect on PC_F next edge. The delay-slot instruction is already in F and enters D normally.
- Stall during a redirect cycle: NPC is discarded, and the redirect is re-evaluated next cycle from the held D-stage inputs.
- Reset asserted mid-stall or mid-redirect: reset values apply next edge regardless.
- npc_sel=BR with br_take=0 behaves exactly as PC4.

Optional Feature:
- Macro: IF_ADDR_EXC_EN.
- Defined:
  - On load, if PC_F[1:0]!=0 or PC_F is outside [IM_BASE, IM_BASE+4*IM_WORDS), instr_D=0 (nop) and exc_D=5'd4 (AdEL).
  - pc_D still records the faulting PC. The PC keeps advancing normally.
- Undefined: no range check; exc_D is constantly 0 and inst_F is passed through unmodified.

Decomposition:
- Shared header macro.vh holds:
  - `Word (31:0) width define.
  - NPC_PC4/NPC_BR/NPC_J/NPC_JR select codes.
  - EXC_NONE and EXC_ADEL codes.
- One natural sub-module, npc: purely combinational next-PC calculator (npc_sel, br_take, PC_F, pc_D, imm16_D, imm26_D, jr_addr_D -> NPC).
- if_stage instantiates npc and holds the PC and IF/ID registers.

Test Plan:
1. Reset for 2 cycles, release with npc_sel=0 -> im_addr 3000, 3004, 3008 on consecutive edges. Cycle after reset release: instr_D=inst_F of 3000, pc_D=3000, pc8_D=3008.
2. pc_D=3004, npc_sel=1, br_take=1, imm16_D=16'hFFFE -> next PC_F=3000. Same with br_take=0 -> PC_F+4.
3. pc_D=3010, npc_sel=2, imm26_D=26'h0000C10 -> PC_F=3040. npc_sel=3, jr_addr_D=3100 -> PC_F=3100. In both cases the delay-slot word reaches instr_D.
4. stall=1 for 3 cycles -> PC_F and all IF/ID fields constant. Add clr_D=1 in the middle cycle -> still held. After release, PC advances by 4.
5. clr_D=1, stall=0 -> instr_D=0, pc_D=0, exc_D=0 next edge while PC_F still advances. Assert reset during a stall -> PC_F=3000 next edge.
6. IF_ADDR_EXC_EN defined, jr_addr_D=3002 -> following cycle instr_D=0, exc_D=4, pc_D=3002. jr to 7000 -> exc_D=4. Macro undefined, same stimulus -> exc_D=0.
